// File: rtl/security_pkg.sv
// Shared types and helpers for the security device lock sequencer.
// States, password width and a small constant-max helper.
package security_pkg;

  localparam int PW_W = 16;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    CHECK    = 3'd1,
    UNLOCKED = 3'd2,
    FAIL     = 3'd3,
    SET_PW   = 3'd4,
    LOCKOUT  = 3'd5
  } lock_state_e;

  function automatic int max3(
    input int a,
    input int b,
    input int c
  );
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/lock_timer.sv
// Shared state-duration counter for the lock sequencer.
// Restarts at 0 on request, otherwise counts up and saturates.
module lock_timer #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         restart,
  output logic [W-1:0] count
);

  logic [W-1:0] r_count;

  // Up-count from zero after each restart; hold at all-ones.
  always_ff @(posedge clk) begin
    if (reset || restart) begin
      r_count <= '0;
    end else if (r_count != '1) begin
      r_count <= r_count + 1'b1;
    end
  end

  assign count = r_count;

endmodule

// File: rtl/lock_controller.sv
// Lock/unlock sequencer: password check, set mode, fail hold and lockout.
// Optional attempt limit and LOCKOUT state built only with LOCKOUT_EN.
module lock_controller
  import security_pkg::*;
#(
  parameter logic [PW_W-1:0] DEFAULT_PW     = 16'h1234,
  parameter int              UNLOCK_CYCLES  = 100_000_000,
  parameter int              FAIL_CYCLES    = 50_000_000,
  parameter int              MAX_ATTEMPTS   = 3,
  parameter int              LOCKOUT_CYCLES = 500_000_000
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [PW_W-1:0] digits,
  input  logic            storageFull,
  input  logic            enter,
  input  logic            newPassword,
  output logic            clear_digits,
  output logic            unlocked,
  output logic            fail,
  output logic            locked_out,
  output logic            set_mode,
  output logic [2:0]      state
);

  localparam int MAX_DUR =
    max3(UNLOCK_CYCLES, FAIL_CYCLES, LOCKOUT_CYCLES);
  localparam int TW = $clog2(MAX_DUR) + 1;

  if (MAX_ATTEMPTS < 1 || MAX_ATTEMPTS > 15 ||
      UNLOCK_CYCLES < 2 || FAIL_CYCLES < 1 ||
      LOCKOUT_CYCLES < 1) begin : g_bad_param
    $error("lock_controller: parameter out of range");
  end

  lock_state_e     r_state;
  lock_state_e     w_state_nxt;
  logic [PW_W-1:0] r_pw;
  logic            r_clear;
  logic            w_clear_nxt;
  logic            w_stay_restart;
  logic            w_restart;
  logic            w_pw_load;
  logic            w_att_inc;
  logic            w_att_clr;
  logic            w_match;
  logic [TW-1:0]   w_count;
  logic            w_unl_exp;
  logic            w_fail_exp;

  lock_timer #(
    .W (TW)
  ) u_timer (
    .clk     (clk),
    .reset   (reset),
    .restart (w_restart),
    .count   (w_count)
  );

  assign w_restart  = (w_state_nxt != r_state) || w_stay_restart;
  assign w_match    = storageFull && (digits == r_pw);
  assign w_unl_exp  = (w_count == TW'(UNLOCK_CYCLES - 1));
  assign w_fail_exp = (w_count == TW'(FAIL_CYCLES - 1));

`ifdef LOCKOUT_EN
  logic [3:0] r_att;
  logic       w_lo_exp;
  logic       w_att_max;

  assign w_lo_exp  = (w_count == TW'(LOCKOUT_CYCLES - 1));
  assign w_att_max = (r_att >= 4'(MAX_ATTEMPTS));

  // Consecutive-failure counter, saturating at 15.
  always_ff @(posedge clk) begin
    if (reset || w_att_clr) begin
      r_att <= '0;
    end else if (w_att_inc && r_att != 4'hF) begin
      r_att <= r_att + 4'd1;
    end
  end
`endif

  // State, password and registered clear pulse.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
      r_pw    <= DEFAULT_PW;
      r_clear <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_clear <= w_clear_nxt;
      if (w_pw_load) begin
        r_pw <= digits;
      end
    end
  end

  // Next state, clear request and side effects; enter beats newPassword.
  always_comb begin
    w_state_nxt    = r_state;
    w_clear_nxt    = 1'b0;
    w_stay_restart = 1'b0;
    w_pw_load      = 1'b0;
    w_att_inc      = 1'b0;
    w_att_clr      = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (enter) begin
          w_state_nxt = CHECK;
          w_clear_nxt = 1'b1;
        end
      end
      CHECK: begin
        if (w_match) begin
          w_state_nxt = UNLOCKED;
          w_att_clr   = 1'b1;
        end else begin
          w_state_nxt = FAIL;
          w_att_inc   = 1'b1;
        end
      end
      UNLOCKED: begin
        if (enter) begin
          w_state_nxt = IDLE;
          w_clear_nxt = 1'b1;
        end else if (newPassword) begin
          w_state_nxt = SET_PW;
          w_clear_nxt = 1'b1;
        end else if (w_unl_exp) begin
          w_state_nxt = IDLE;
          w_clear_nxt = 1'b1;
        end
      end
      FAIL: begin
        if (w_fail_exp) begin
          w_state_nxt = IDLE;
`ifdef LOCKOUT_EN
          if (w_att_max) begin
            w_state_nxt = LOCKOUT;
            w_clear_nxt = 1'b1;
          end
`endif
        end
      end
      SET_PW: begin
        if (enter) begin
          w_clear_nxt = 1'b1;
          if (storageFull) begin
            w_pw_load   = 1'b1;
            w_state_nxt = UNLOCKED;
          end else begin
            w_stay_restart = 1'b1;
          end
        end else if (newPassword) begin
          w_state_nxt = UNLOCKED;
          w_clear_nxt = 1'b1;
        end else if (w_unl_exp) begin
          w_state_nxt = IDLE;
          w_clear_nxt = 1'b1;
        end
      end
`ifdef LOCKOUT_EN
      LOCKOUT: begin
        if (w_lo_exp) begin
          w_state_nxt = IDLE;
          w_clear_nxt = 1'b1;
          w_att_clr   = 1'b1;
        end
      end
`endif
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  assign clear_digits = r_clear;
  assign unlocked     = (r_state == UNLOCKED) ||
                        (r_state == SET_PW);
  assign fail         = (r_state == FAIL);
  assign set_mode     = (r_state == SET_PW);
  assign state        = r_state;
`ifdef LOCKOUT_EN
  assign locked_out   = (r_state == LOCKOUT);
`else
  assign locked_out   = 1'b0;
`endif

endmodule

// File: tb/tb_lock_controller.sv
// Directed self-checking bench for lock_controller.
// Lockout scenarios run when LOCKOUT_EN is defined.
module tb_lock_controller;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] digits;
  logic        storageFull;
  logic        enter;
  logic        newPassword;
  logic        clear_digits;
  logic        unlocked;
  logic        fail;
  logic        locked_out;
  logic        set_mode;
  logic [2:0]  state;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  lock_controller #(
    .DEFAULT_PW     (16'h1234),
    .UNLOCK_CYCLES  (8),
    .FAIL_CYCLES    (4),
    .MAX_ATTEMPTS   (3),
    .LOCKOUT_CYCLES (16)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .digits       (digits),
    .storageFull  (storageFull),
    .enter        (enter),
    .newPassword  (newPassword),
    .clear_digits (clear_digits),
    .unlocked     (unlocked),
    .fail         (fail),
    .locked_out   (locked_out),
    .set_mode     (set_mode),
    .state        (state)
  );

  task automatic check(
    input string       tag,
    input logic [31:0] got,
    input logic [31:0] exp
  );
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h",
               tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Pulse enter, then advance past the CHECK cycle.
  task automatic do_enter(
    input logic [15:0] d,
    input logic        full
  );
    digits      = d;
    storageFull = full;
    enter       = 1'b1;
    step();
    enter       = 1'b0;
    step();
  endtask

  task automatic lock_now();
    enter = 1'b1;
    step();
    enter = 1'b0;
    check("lock_st", 32'(state), 32'd0);
    check("lock_clr", 32'(clear_digits), 32'd1);
  endtask

  task automatic fail_once(
    input logic [15:0] d,
    input logic        full,
    input logic        exp_lo
  );
    do_enter(d, full);
    check("fail_on", 32'(fail), 32'd1);
    repeat (3) step();
    check("fail_hold", 32'(fail), 32'd1);
    check("fail_no_lo", 32'(locked_out), 32'd0);
    step();
    check("fail_done", 32'(fail), 32'd0);
    check("lo_entry", 32'(locked_out), 32'(exp_lo));
    check("post_fail_st", 32'(state),
          exp_lo ? 32'd5 : 32'd0);
  endtask

  initial begin
    reset       = 1'b1;
    digits      = 16'h0000;
    storageFull = 1'b0;
    enter       = 1'b0;
    newPassword = 1'b0;
    step();
    reset = 1'b0;
    check("rst_st", 32'(state), 32'd0);
    check("rst_unl", 32'(unlocked), 32'd0);
    check("rst_fail", 32'(fail), 32'd0);
    check("rst_lo", 32'(locked_out), 32'd0);
    check("rst_set", 32'(set_mode), 32'd0);
    check("rst_clr", 32'(clear_digits), 32'd0);

    // 1: default password unlocks, then auto-relock
    digits      = 16'h1234;
    storageFull = 1'b1;
    enter       = 1'b1;
    step();
    enter = 1'b0;
    check("chk_st", 32'(state), 32'd1);
    check("chk_clr", 32'(clear_digits), 32'd1);
    check("chk_unl", 32'(unlocked), 32'd0);
    step();
    check("unl_on", 32'(unlocked), 32'd1);
    check("unl_st", 32'(state), 32'd2);
    check("unl_clr0", 32'(clear_digits), 32'd0);
    repeat (7) step();
    check("unl_hold", 32'(unlocked), 32'd1);
    step();
    check("relock_unl", 32'(unlocked), 32'd0);
    check("relock_clr", 32'(clear_digits), 32'd1);
    check("relock_st", 32'(state), 32'd0);
    step();
    check("relock_clr0", 32'(clear_digits), 32'd0);

`ifdef LOCKOUT_EN
    // 2: three failures lead to lockout
    fail_once(16'h9999, 1'b1, 1'b0);
    fail_once(16'h9999, 1'b1, 1'b0);
    fail_once(16'h9999, 1'b1, 1'b1);
    check("lo_in_clr", 32'(clear_digits), 32'd1);
    digits = 16'h1234;
    enter  = 1'b1;
    step();
    enter = 1'b0;
    check("lo_ign_st", 32'(state), 32'd5);
    check("lo_ign_clr", 32'(clear_digits), 32'd0);
    repeat (14) step();
    check("lo_hold", 32'(locked_out), 32'd1);
    step();
    check("lo_exit", 32'(locked_out), 32'd0);
    check("lo_exit_st", 32'(state), 32'd0);
    check("lo_out_clr", 32'(clear_digits), 32'd1);
    do_enter(16'h1234, 1'b1);
    check("lo_after_unl", 32'(unlocked), 32'd1);
    lock_now();
`else
    // 6: no lockout build, repeated failures
    for (int i = 0; i < 5; i++) begin
      fail_once(16'h9999, 1'b1, 1'b0);
    end
`endif

    // 3: change password to 0420
    do_enter(16'h1234, 1'b1);
    check("t3_unl", 32'(unlocked), 32'd1);
    newPassword = 1'b1;
    step();
    newPassword = 1'b0;
    check("set_st", 32'(state), 32'd4);
    check("set_mode", 32'(set_mode), 32'd1);
    check("set_unl", 32'(unlocked), 32'd1);
    check("set_clr", 32'(clear_digits), 32'd1);
    digits      = 16'h0420;
    storageFull = 1'b1;
    enter       = 1'b1;
    step();
    enter = 1'b0;
    check("newpw_st", 32'(state), 32'd2);
    check("newpw_set0", 32'(set_mode), 32'd0);
    check("newpw_clr", 32'(clear_digits), 32'd1);
    lock_now();
    do_enter(16'h1234, 1'b1);
    check("oldpw_fail", 32'(fail), 32'd1);
    repeat (4) step();
    check("oldpw_idle", 32'(state), 32'd0);
    do_enter(16'h0420, 1'b1);
    check("newpw_unl", 32'(unlocked), 32'd1);
    lock_now();

    // 4: storageFull gating
    do_enter(16'h0420, 1'b0);
    check("empty_fail", 32'(fail), 32'd1);
    repeat (4) step();
    check("empty_idle", 32'(state), 32'd0);
    do_enter(16'h0420, 1'b1);
    newPassword = 1'b1;
    step();
    newPassword = 1'b0;
    digits      = 16'h5555;
    storageFull = 1'b0;
    enter       = 1'b1;
    step();
    enter = 1'b0;
    check("setnf_st", 32'(state), 32'd4);
    check("setnf_clr", 32'(clear_digits), 32'd1);
    newPassword = 1'b1;
    step();
    newPassword = 1'b0;
    check("abort_st", 32'(state), 32'd2);
    check("abort_clr", 32'(clear_digits), 32'd1);
    lock_now();
    fail_once(16'h5555, 1'b1, 1'b0);
    do_enter(16'h0420, 1'b1);
    check("pw_kept", 32'(unlocked), 32'd1);

    // 5: enter wins over newPassword
    enter       = 1'b1;
    newPassword = 1'b1;
    step();
    enter       = 1'b0;
    newPassword = 1'b0;
    check("both_st", 32'(state), 32'd0);
    check("both_set", 32'(set_mode), 32'd0);
    check("both_clr", 32'(clear_digits), 32'd1);

`ifdef LOCKOUT_EN
    fail_once(16'h9999, 1'b1, 1'b0);
    fail_once(16'h9999, 1'b1, 1'b0);
    fail_once(16'h9999, 1'b1, 1'b1);
    repeat (3) step();
    check("pre_rst_lo", 32'(locked_out), 32'd1);
`else
    do_enter(16'h0420, 1'b1);
    check("pre_rst_unl", 32'(unlocked), 32'd1);
`endif
    reset = 1'b1;
    step();
    reset = 1'b0;
    check("mid_rst_st", 32'(state), 32'd0);
    check("mid_rst_lo", 32'(locked_out), 32'd0);
    check("mid_rst_unl", 32'(unlocked), 32'd0);
    check("mid_rst_clr", 32'(clear_digits), 32'd0);
    do_enter(16'h1234, 1'b1);
    check("dflt_pw_back", 32'(unlocked), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
